// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with a valid/ready request port and a one-entry registered response.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CHK_W = ADDR_W + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state, state_nxt;
    logic [7:0]       mem [DEPTH_BYTES];
    logic             accept_c;
    logic [3:0]       be_c;
    logic [1:0]       span_c;
    logic             size_bad_c;
    logic [CHK_W-1:0] last_addr_c;
    logic             oob_c;
    logic             misalign_c;
    logic             err_c;
    logic [IDX_W-1:0] idx_c;
    logic [7:0]       rd_b [4];
    logic             sx_c;
    logic [31:0]      load_c;
    logic [31:0]      rdata_nxt_c;

    assign resp_valid = (state == RESP);
    assign req_ready  = !resp_valid || resp_ready;
    assign accept_c   = req_valid && req_ready;
    assign idx_c      = req_addr[IDX_W-1:0];

    // Byte enables and extra bytes beyond the first for each access size
    always_comb begin
        be_c       = 4'b0000;
        span_c     = 2'd0;
        size_bad_c = 1'b0;
        case (req_size)
            2'b00:   begin be_c = 4'b0001; span_c = 2'd0; end
            2'b01:   begin be_c = 4'b0011; span_c = 2'd1; end
            2'b10:   begin be_c = 4'b1111; span_c = 2'd3; end
            default: size_bad_c = 1'b1;
        endcase
    end

    // One extra bit keeps addr+span from wrapping past the top of the address space
    assign last_addr_c = {1'b0, req_addr} + CHK_W'(span_c);
    assign oob_c       = (last_addr_c >= CHK_W'(DEPTH_BYTES));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign err_c = size_bad_c || oob_c || misalign_c;

    // Little-endian gather; indices wrap harmlessly since out-of-range accesses are errors
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_b[k] = mem[idx_c + IDX_W'(k)];
        end
    end

    assign sx_c = !req_unsigned;

    always_comb begin
        load_c = 32'h0;
        case (req_size)
            2'b00:   load_c = {{24{sx_c & rd_b[0][7]}}, rd_b[0]};
            2'b01:   load_c = {{16{sx_c & rd_b[1][7]}}, rd_b[1], rd_b[0]};
            2'b10:   load_c = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
            default: load_c = 32'h0;
        endcase
    end

    assign rdata_nxt_c = (req_wr || err_c) ? 32'h0 : load_c;

    // Storage is never reset
    always_ff @(posedge clk) begin
        if (accept_c && req_wr && !err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (be_c[k]) begin
                    mem[idx_c + IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new accept in RESP reloads the response instead of draining it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = RESP;
            RESP: begin
                if (accept_c) begin
                    state_nxt = RESP;
                end else if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept_c) begin
            resp_rdata <= rdata_nxt_c;
            resp_err   <= err_c;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stores, signed/unsigned loads, backpressure, bounds, alignment, reset.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    data_mem_ctrl #(.DEPTH_BYTES(1024), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request at a falling edge, after letting any pending response drain
    task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic rr);
        @(negedge clk);
        if (resp_valid) begin
            resp_ready = 1'b1;
            @(negedge clk);
        end
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        resp_ready   = rr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] d, input logic e);
        chk({tag, "/valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "/rdata"}, resp_rdata, d);
        chk({tag, "/err"}, {31'h0, resp_err}, {31'h0, e});
    endtask

    task automatic do_st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic e);
        xact(1'b1, sz, 1'b0, a, wd, 1'b1);
        expect_resp(tag, 32'h0, e);
    endtask

    task automatic do_ld(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic e);
        xact(1'b0, sz, uns, a, 32'h0, 1'b1);
        expect_resp(tag, d, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;
        #1;
        chk("rst/valid", {31'h0, resp_valid}, 32'h0);
        chk("rst/rdata", resp_rdata, 32'h0);
        chk("rst/err", {31'h0, resp_err}, 32'h0);
        chk("rst/ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sign/zero extension of a byte inside a stored word
        do_st("st_w4", 2'b10, 32'd4, 32'h8899AABB, 1'b0);
        do_ld("ld_b5s", 2'b00, 1'b0, 32'd5, 32'hFFFFFFAA, 1'b0);
        do_ld("ld_b5u", 2'b00, 1'b1, 32'd5, 32'h000000AA, 1'b0);

        // Half store merges into a word; only low wdata bytes are used
        do_st("st_w8", 2'b10, 32'd8, 32'h44332211, 1'b0);
        do_st("st_h10", 2'b01, 32'd10, 32'hDEAD1234, 1'b0);
        do_ld("ld_w8", 2'b10, 1'b0, 32'd8, 32'h12342211, 1'b0);
        do_ld("ld_h10s", 2'b01, 1'b0, 32'd10, 32'h00001234, 1'b0);
        do_st("st_h12", 2'b01, 32'd12, 32'h00008001, 1'b0);
        do_ld("ld_h12s", 2'b01, 1'b0, 32'd12, 32'hFFFF8001, 1'b0);
        do_ld("ld_h12u", 2'b01, 1'b1, 32'd12, 32'h00008001, 1'b0);
        do_ld("ld_w4u", 2'b10, 1'b1, 32'd4, 32'h8899AABB, 1'b0);

        // Backpressure: response held, then back-to-back accept on release
        xact(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold/valid", {31'h0, resp_valid}, 32'h1);
            chk("hold/rdata", resp_rdata, 32'h8899AABB);
            chk("hold/ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid    = 1'b1;
        req_wr       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        req_addr     = 32'd4;
        resp_ready   = 1'b1;
        #1;
        chk("b2b/ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        expect_resp("b2b", 32'h000000BB, 1'b0);

        // Bounds checks at the top of memory and for illegal size / wrapping addresses
        do_st("st_h1022", 2'b01, 32'd1022, 32'h0000A55A, 1'b0);
        do_st("st_w1022", 2'b10, 32'd1022, 32'h11223344, 1'b1);
        do_ld("ld_h1022", 2'b01, 1'b1, 32'd1022, 32'h0000A55A, 1'b0);
        do_ld("ld_w1022", 2'b10, 1'b0, 32'd1022, 32'h0, 1'b1);
        do_ld("ld_b1023", 2'b00, 1'b1, 32'd1023, 32'h000000A5, 1'b0);
        do_ld("ld_sz3", 2'b11, 1'b0, 32'd0, 32'h0, 1'b1);
        do_ld("ld_wtop", 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_ld("ld_b1024", 2'b00, 1'b0, 32'd1024, 32'h0, 1'b1);

        // Reset while a response is held
        xact(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 1'b0);
        chk("pre_rst/valid", {31'h0, resp_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst/valid", {31'h0, resp_valid}, 32'h0);
        chk("mid_rst/rdata", resp_rdata, 32'h0);
        chk("mid_rst/ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst/valid", {31'h0, resp_valid}, 32'h0);
        do_ld("post_rst/w8", 2'b10, 1'b0, 32'd8, 32'h12342211, 1'b0);

        // Misaligned word store at addr 2
        do_st("st_w0", 2'b10, 32'd0, 32'h00000000, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        do_st("st_w2", 2'b10, 32'd2, 32'hCAFEF00D, 1'b1);
        do_ld("ld_w0", 2'b10, 1'b0, 32'd0, 32'h00000000, 1'b0);
        do_ld("ld_w4b", 2'b10, 1'b0, 32'd4, 32'h8899AABB, 1'b0);
        do_ld("ld_w2", 2'b10, 1'b0, 32'd2, 32'h0, 1'b1);
`else
        do_st("st_w2", 2'b10, 32'd2, 32'hCAFEF00D, 1'b0);
        do_ld("ld_w0", 2'b10, 1'b0, 32'd0, 32'hF00D0000, 1'b0);
        do_ld("ld_w4b", 2'b10, 1'b0, 32'd4, 32'h8899CAFE, 1'b0);
        do_ld("ld_w2", 2'b10, 1'b0, 32'd2, 32'hCAFEF00D, 1'b0);
`endif

        @(negedge clk);
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
